// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and defaults for the EX->MEM pipeline register.
//   ctrl_t       : control bundle {RegWrite, MemtoReg, MemWrite}
//   *_D          : default field widths
//   payload_w()  : packed payload width carried through each stage
package ex_mem_pkg;

    localparam int DATA_W_D = 32;
    localparam int REG_W_D  = 5;
    localparam int CTRL_W_D = 3;

    // Bit positions of the control bundle
    localparam int CTRL_RW  = 2;
    localparam int CTRL_M2R = 1;
    localparam int CTRL_MW  = 0;

    typedef struct packed {
        logic rw;   // bit 2: RegWrite
        logic m2r;  // bit 1: MemtoReg
        logic mw;   // bit 0: MemWrite
    } ctrl_t;

    function automatic int payload_w(input int dw, input int rw, input int cw);
        return 2 * dw + rw + cw;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_stage.sv
// skid_stage: one main + skid register pair with valid/ready handshake.
// in_ready_o is taken straight from the skid valid flop, so there is no
// combinational path from out_ready_i back to the upstream side.
// Ports:
//   clk, reset         : clock, async active-high reset
//   flush_i            : synchronous kill of both entries (data held)
//   in_valid_i/in_ready_o/in_data_i    : upstream side
//   out_valid_o/out_ready_i/out_data_o : downstream side
module skid_stage #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic         accept, fire;

    assign in_ready_o  = ~skid_vld_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        accept     = in_valid_i & ~skid_vld_q;
        fire       = main_vld_q & out_ready_i;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || fire) begin
            // Main slot frees up: the older skid entry goes first.
            skid_vld_d = 1'b0;
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
            end else if (accept) begin
                main_d     = in_data_i;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stuck; park the new entry so in_ready can stay registered.
            skid_d     = in_data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register with valid/ready handshake,
// STAGES cascaded skid stages (capacity 2*STAGES), synchronous flush and
// control-bit masking so a bubble never presents write enables to MEM.
// Optional build macro EX_MEM_STALL_CNT_EN adds the saturating stall_count.
// Ports:
//   clk, reset, flush                 : clock, async active-high reset, sync kill
//   in_valid/in_ready + in_*          : EX side entry
//   out_valid/out_ready + out_*       : MEM side entry; out_ctrl masked by out_valid
//   stall_count                       : cycles with in_valid & ~in_ready (macro only)
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int REG_W  = REG_W_D,
    parameter int CTRL_W = CTRL_W_D,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [REG_W-1:0]  in_write_reg,
    input  logic [CTRL_W-1:0] in_ctrl,
`ifdef EX_MEM_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_count,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_write_data,
    output logic [REG_W-1:0]  out_write_reg,
    output logic [CTRL_W-1:0] out_ctrl
);

    localparam int PW = payload_w(DATA_W, REG_W, CTRL_W);

    // Index k is the boundary in front of stage k; index STAGES is the MEM side.
    logic [STAGES:0]         vld;
    logic [STAGES:0]         rdy;
    logic [STAGES:0][PW-1:0] pl;
    logic [CTRL_W-1:0]       ctrl_raw;

    assign vld[0]      = in_valid;
    assign pl[0]       = {in_alu_out, in_write_data, in_write_reg, in_ctrl};
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        skid_stage #(.W(PW)) u_stg (
            .clk         (clk),
            .reset       (reset),
            .flush_i     (flush),
            .in_valid_i  (vld[k]),
            .in_ready_o  (rdy[k]),
            .in_data_i   (pl[k]),
            .out_valid_o (vld[k+1]),
            .out_ready_i (rdy[k+1]),
            .out_data_o  (pl[k+1])
        );
    end

    assign out_valid = vld[STAGES];
    assign {out_alu_out, out_write_data, out_write_reg, ctrl_raw} = pl[STAGES];
    assign out_ctrl  = ctrl_raw & {CTRL_W{out_valid}};

`ifdef EX_MEM_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && stall_q != {CNT_W{1'b1}})
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Cleared by reset only; flush leaves the statistic alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
